// File: rtl/seq_pkg.sv
// Shared types and reset pattern for the note sequencer.
package seq_pkg;

  localparam int unsigned NUM_NOTES = 4;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} seq_state_t;

  typedef struct packed {
    logic                         rest;
    logic [$clog2(NUM_NOTES)-1:0] note;
  } seq_step_t;

  // Power-up melody: rising then falling scale, final step is a rest.
  function automatic seq_step_t default_step(input int unsigned idx);
    seq_step_t s;
    s.rest = 1'b0;
    case (idx)
      0: s.note = 2'd0;
      1: s.note = 2'd1;
      2: s.note = 2'd2;
      3: s.note = 2'd3;
      4: s.note = 2'd2;
      5: s.note = 2'd1;
      6: s.note = 2'd0;
      default: begin
        s.rest = 1'b1;
        s.note = 2'd0;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_pattern_ram.sv
// Melody pattern register file: one write port, one combinational read port.
module seq_pattern_ram
  import seq_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       WR_EN,
  input  logic [$clog2(SEQ_LEN)-1:0] WR_ADDR,
  input  seq_step_t                  WR_DATA,
  input  logic [$clog2(SEQ_LEN)-1:0] RD_ADDR,
  output seq_step_t                  RD_DATA
);

  seq_step_t mem [SEQ_LEN];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < SEQ_LEN; i++) mem[i] <= default_step(i);
    end else if (WR_EN) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

  assign RD_DATA = mem[RD_ADDR];

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: plays the stored pattern by driving oscillator NOTE_SEL and an audio GATE.
module note_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES  = 500_000,
  parameter int unsigned SEQ_LEN     = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       START,
  input  logic                       STOP,
  input  logic                       LOOP,
  input  logic                       WR_EN,
  input  logic [$clog2(SEQ_LEN)-1:0] WR_ADDR,
  input  logic [2:0]                 WR_DATA,
  output logic [1:0]                 NOTE_SEL,
  output logic                       GATE,
  output logic [$clog2(SEQ_LEN)-1:0] STEP_IDX,
  output logic                       BUSY,
  output logic                       DONE
);

  localparam int unsigned AW = $clog2(SEQ_LEN);
  localparam int unsigned CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] PLAY_LAST = CW'(STEP_CYCLES - GAP_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(SEQ_LEN - 1);
  localparam bit            HAS_GAP   = (GAP_CYCLES != 0);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    note_q, note_d;
  logic          gate_q, gate_d;
  logic          done_q, done_d;
  logic [AW-1:0] rd_addr;
  seq_step_t     rd_data;
  logic          load;
  logic          step_end;

  seq_pattern_ram #(.SEQ_LEN(SEQ_LEN)) u_ram (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .WR_EN   (WR_EN),
    .WR_ADDR (WR_ADDR),
    .WR_DATA (seq_step_t'(WR_DATA)),
    .RD_ADDR (rd_addr),
    .RD_DATA (rd_data)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      note_q  <= '0;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
    end
  end

  // With no gap the PLAY phase covers the whole step, so PLAY ends the step itself.
  assign step_end = (state_q == GAP  && cnt_q == STEP_LAST) ||
                    (state_q == PLAY && !HAS_GAP && cnt_q == PLAY_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    note_d  = note_q;
    gate_d  = gate_q;
    done_d  = 1'b0;
    rd_addr = '0;
    load    = 1'b0;
    if (STOP) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      gate_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: load = START;
        PLAY, GAP: begin
          if (step_end) begin
            if (idx_q != LAST_IDX) begin
              load    = 1'b1;
              rd_addr = idx_q + AW'(1);
            end else if (LOOP) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              gate_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else if (state_q == PLAY && cnt_q == PLAY_LAST) begin
            state_d = GAP;
            gate_d  = 1'b0;
            cnt_d   = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Pattern read is pre-edge, so a same-edge write to this entry is not seen.
    if (load) begin
      state_d = PLAY;
      cnt_d   = '0;
      idx_d   = rd_addr;
      note_d  = rd_data.note;
      gate_d  = !rd_data.rest;
    end
  end

  assign NOTE_SEL = note_q;
  assign GATE     = gate_q;
  assign STEP_IDX = idx_q;
  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench: two builds (gap and no-gap) share stimulus, checked against a step-position model.
module tb_note_sequencer;

  localparam int STEP = 10;
  localparam int LEN  = 8;

  typedef struct packed {
    logic [1:0] note;
    logic       gate;
    logic [2:0] idx;
    logic       busy;
    logic       done;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST_N, START, STOP, LOOP, WR_EN;
  logic [2:0] WR_ADDR, WR_DATA;

  logic [1:0] note0, note1;
  logic       gate0, gate1, busy0, busy1, done0, done1;
  logic [2:0] idx0, idx1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  note_sequencer #(.STEP_CYCLES(10), .GAP_CYCLES(2), .SEQ_LEN(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .LOOP(LOOP),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .NOTE_SEL(note0), .GATE(gate0), .STEP_IDX(idx0), .BUSY(busy0), .DONE(done0)
  );

  note_sequencer #(.STEP_CYCLES(10), .GAP_CYCLES(0), .SEQ_LEN(8)) dut_nogap (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .LOOP(LOOP),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .NOTE_SEL(note1), .GATE(gate1), .STEP_IDX(idx1), .BUSY(busy1), .DONE(done1)
  );

  // Reference model: per build, playing flag plus cycle offset within the current step.
  int         gap_len [2] = '{2, 0};
  bit         m_active[2];
  int         m_pos   [2];
  int         m_idx   [2];
  logic [2:0] m_cur   [2];
  logic [1:0] m_note  [2];
  bit         m_done  [2];
  logic [2:0] m_pat   [2][LEN];
  exp_t       q0[$];
  exp_t       q1[$];

  function automatic logic [2:0] dflt(input int i);
    int notes[7] = '{0, 1, 2, 3, 2, 1, 0};
    if (i < 7) return {1'b0, 2'(notes[i])};
    return 3'b100;
  endfunction

  task automatic model_reset(input int u);
    m_active[u] = 0; m_pos[u] = 0; m_idx[u] = 0;
    m_cur[u] = '0; m_note[u] = '0; m_done[u] = 0;
    for (int i = 0; i < LEN; i++) m_pat[u][i] = dflt(i);
  endtask

  task automatic model_load(input int u, input int i);
    m_idx[u] = i; m_cur[u] = m_pat[u][i]; m_note[u] = m_cur[u][1:0];
    m_pos[u] = 0; m_active[u] = 1;
  endtask

  task automatic model_edge(input int u);
    exp_t e;
    m_done[u] = 0;
    if (!RST_N) model_reset(u);
    else begin
      if (STOP) begin
        m_active[u] = 0; m_idx[u] = 0;
      end else if (!m_active[u]) begin
        if (START) model_load(u, 0);
      end else begin
        m_pos[u]++;
        if (m_pos[u] == STEP) begin
          if (m_idx[u] < LEN - 1) model_load(u, m_idx[u] + 1);
          else if (LOOP) model_load(u, 0);
          else begin m_active[u] = 0; m_done[u] = 1; end
        end
      end
      if (WR_EN) m_pat[u][WR_ADDR] = WR_DATA;
    end
    e.note = m_note[u];
    e.gate = m_active[u] && !m_cur[u][2] && (m_pos[u] < STEP - gap_len[u]);
    e.idx  = 3'(m_idx[u]);
    e.busy = m_active[u];
    e.done = m_done[u];
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  always @(posedge CLK) begin
    model_edge(0);
    model_edge(1);
  end

  always @(negedge RST_N) begin
    q0.delete(); q1.delete();
    model_reset(0); model_reset(1);
  end

  task automatic cmp(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s unit%0d t=%0t: got %0d expected %0d", name, u, $time, act, exp);
    end
  endtask

  task automatic check_unit(input int u, input exp_t e);
    if (u == 0) begin
      cmp("note_sel", 0, 32'(note0), 32'(e.note)); cmp("gate", 0, 32'(gate0), 32'(e.gate));
      cmp("step_idx", 0, 32'(idx0), 32'(e.idx));   cmp("busy", 0, 32'(busy0), 32'(e.busy));
      cmp("done", 0, 32'(done0), 32'(e.done));
    end else begin
      cmp("note_sel", 1, 32'(note1), 32'(e.note)); cmp("gate", 1, 32'(gate1), 32'(e.gate));
      cmp("step_idx", 1, 32'(idx1), 32'(e.idx));   cmp("busy", 1, 32'(busy1), 32'(e.busy));
      cmp("done", 1, 32'(done1), 32'(e.done));
    end
  endtask

  always @(negedge CLK) begin
    if (q0.size() > 0) check_unit(0, q0.pop_front());
    if (q1.size() > 0) check_unit(1, q1.pop_front());
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_start();
    START = 1'b1; @(negedge CLK); START = 1'b0;
  endtask

  task automatic write_step(input int a, input logic [2:0] d);
    WR_EN = 1'b1; WR_ADDR = 3'(a); WR_DATA = d;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  initial begin
    int k;
    bit got;
    RST_N = 1'b0; START = 1'b0; STOP = 1'b0; LOOP = 1'b0;
    WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    cycles(3);
    RST_N = 1'b1;
    cycles(2);

    // Single non-loop run; DONE must appear 81 cycles after START.
    START = 1'b1; k = 0; got = 0;
    while (k < 200 && !got) begin
      @(negedge CLK); START = 1'b0; k++;
      if (done0 === 1'b1) got = 1;
    end
    cmp("done_latency", 0, 32'(k), 32'd81);
    cycles(5);

    // Looping run: three passes, LOOP dropped during the third.
    LOOP = 1'b1;
    pulse_start();
    cycles(164);
    LOOP = 1'b0;
    cycles(90);

    // STOP at cycle 25, then START and STOP together.
    pulse_start();
    cycles(24);
    STOP = 1'b1; @(negedge CLK); STOP = 1'b0;
    cycles(2);
    START = 1'b1; STOP = 1'b1; @(negedge CLK); START = 1'b0; STOP = 1'b0;
    cycles(4);

    // Pattern writes while playing: step 4 becomes a rest, step 3 changes next pass.
    LOOP = 1'b1;
    pulse_start();
    cycles(24);
    write_step(4, 3'b110);
    cycles(9);
    write_step(3, 3'b000);
    cycles(135);
    STOP = 1'b1; @(negedge CLK); STOP = 1'b0;
    LOOP = 1'b0;
    cycles(3);

    // Asynchronous reset in step 5 with a modified pattern in place.
    pulse_start();
    cycles(54);
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    cmp("rst_note", 0, 32'(note0), 0); cmp("rst_gate", 0, 32'(gate0), 0);
    cmp("rst_idx", 0, 32'(idx0), 0);   cmp("rst_busy", 0, 32'(busy0), 0);
    cmp("rst_done", 0, 32'(done0), 0); cmp("rst_note", 1, 32'(note1), 0);
    cmp("rst_gate", 1, 32'(gate1), 0); cmp("rst_busy", 1, 32'(busy1), 0);
    cycles(2);
    RST_N = 1'b1;
    cycles(1);
    pulse_start();
    cycles(90);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      START   = ($urandom % 8) == 0;
      STOP    = ($urandom % 64) == 0;
      LOOP    = ($urandom % 4) != 0;
      WR_EN   = ($urandom % 4) == 0;
      WR_ADDR = 3'($urandom);
      WR_DATA = 3'($urandom);
      @(negedge CLK);
    end
    START = 1'b0; STOP = 1'b0; WR_EN = 1'b0;
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
